// File: rtl/addsub_halffull.sv
// Registered 1-bit adder/subtractor, selectable half or full structure.
// One result per qualified input cycle, presented one clock later.
module addsub_halffull (
  input  logic clk,
  input  logic rst_n,
  input  logic mode_addsub,
  input  logic mode_halffull,
  input  logic signal_a,
  input  logic signal_b,
  input  logic carryborrow_in,
  input  logic in_valid,
  output logic carryborrow_out,
  output logic sumdiff,
  output logic out_valid
);

  // Handshake: in_valid qualifies every input on the same rising edge; there is
  // no ready, so each valid input yields exactly one out_valid pulse a cycle later.
  logic w_c;
  logic w_axb;
  logic w_sum;
  logic w_carry;
  logic w_borrow;
  logic w_cbo;

  logic r_cbo;
  logic r_sd;
  logic r_valid;

  // AND gating forces c to 0 in half mode even when carryborrow_in is unknown.
  assign w_c      = mode_halffull & carryborrow_in;
  assign w_axb    = signal_a ^ signal_b;
  assign w_sum    = w_axb ^ w_c;
  assign w_carry  = (signal_a & signal_b) | (w_c & w_axb);
  assign w_borrow = (~signal_a & signal_b) | (w_c & ~w_axb);
  assign w_cbo    = mode_addsub ? w_borrow : w_carry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cbo   <= 1'b0;
      r_sd    <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_cbo <= w_cbo;
        r_sd  <= w_sum;
      end
    end
  end

  assign carryborrow_out = r_cbo;
  assign sumdiff         = r_sd;
  assign out_valid       = r_valid;

endmodule

// File: tb/tb_addsub_halffull.sv
// Self-checking bench for addsub_halffull: directed sweeps, mode switching,
// resets, then random traffic against an arithmetic reference model.
module tb_addsub_halffull;

  logic clk;
  logic rst_n;
  logic mode_addsub;
  logic mode_halffull;
  logic signal_a;
  logic signal_b;
  logic carryborrow_in;
  logic in_valid;
  logic carryborrow_out;
  logic sumdiff;
  logic out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] exp_q[$];
  logic [1:0] exp_out;
  logic       exp_ov;

  addsub_halffull dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mode_addsub     (mode_addsub),
    .mode_halffull   (mode_halffull),
    .signal_a        (signal_a),
    .signal_b        (signal_b),
    .carryborrow_in  (carryborrow_in),
    .in_valid        (in_valid),
    .carryborrow_out (carryborrow_out),
    .sumdiff         (sumdiff),
    .out_valid       (out_valid)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [1:0] ref_model(input logic sub, input logic full,
                                           input logic a, input logic b, input logic cin);
    int c;
    int r;
    logic [1:0] res;
    c = full ? int'(cin) : 0;
    if (!sub) begin
      r = int'(a) + int'(b) + c;
      res = {r[1], r[0]};
    end else begin
      r = int'(a) - int'(b) - c;
      res[0] = r[0];
      res[1] = (int'(a) < int'(b) + c);
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // driver: apply one cycle of inputs, then compare against the scoreboard
  task automatic step(input string tag, input logic rst, input logic sub, input logic full,
                      input logic a, input logic b, input logic cin, input logic v);
    rst_n          = rst;
    mode_addsub    = sub;
    mode_halffull  = full;
    signal_a       = a;
    signal_b       = b;
    carryborrow_in = cin;
    in_valid       = v;
    @(posedge clk);
    #1;
    if (!rst) begin
      exp_q.delete();
      exp_out = 2'b00;
      exp_ov  = 1'b0;
    end else if (v) begin
      exp_q.push_back(ref_model(sub, full, a, b, cin));
    end
    if (rst && exp_q.size() > 0) begin
      exp_out = exp_q.pop_front();
      exp_ov  = 1'b1;
    end else begin
      exp_ov = 1'b0;
    end
    check({tag, "_out"},   {carryborrow_out, sumdiff}, exp_out);
    check({tag, "_valid"}, {1'b0, out_valid},          {1'b0, exp_ov});
  endtask

  initial begin
    logic [2:0] abc;
    exp_out = 2'b00;
    exp_ov  = 1'b0;

    // reset held two cycles with valid operands present
    step("reset0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step("reset1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    // full add / full sub / half add / half sub sweeps
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 8; i++) begin
        abc = 3'(i);
        step($sformatf("sweep_m%0d_%0d", m, i), 1'b1, m[0], ~m[1],
             abc[2], abc[1], abc[0], 1'b1);
      end
    end

    // spot checks against literal tables for the full sweeps' edge values
    step("full_add_111", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("full_add_111_tbl", {carryborrow_out, sumdiff}, 2'b11);
    step("full_sub_001", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("full_sub_001_tbl", {carryborrow_out, sumdiff}, 2'b11);
    step("half_sub_011", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("half_sub_011_tbl", {carryborrow_out, sumdiff}, 2'b11);

    // mode switching with a gap cycle
    step("mode_add", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("mode_add_tbl", {carryborrow_out, sumdiff}, 2'b01);
    step("mode_sub", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("mode_sub_tbl", {carryborrow_out, sumdiff}, 2'b11);
    step("gap", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("gap_hold_tbl", {carryborrow_out, sumdiff}, 2'b11);
    step("resume_add", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step("resume_sub", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // mid-stream reset during a full add sweep
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      step($sformatf("midrst_%0d", i), (i != 4), 1'b0, 1'b1, abc[2], abc[1], abc[0], 1'b1);
    end

    // random traffic
    for (int i = 0; i < 300; i++) begin
      step($sformatf("rand_%0d", i), ($urandom_range(0, 19) != 0),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_halffull.md
ADDSUB_HALFFULL -- requirements
Module: addsub_halffull

Interface
REQ-001 Parameters: none; the block is fixed 1-bit wide.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-004 mode_addsub  input  1  operation select: 0 = add, 1 = subtract.
REQ-005 mode_halffull  input  1  structure select: 0 = half (carryborrow_in ignored), 1 = full (carryborrow_in used).
REQ-006 signal_a  input  1  operand A (minuend in subtract mode).
REQ-007 signal_b  input  1  operand B (subtrahend in subtract mode).
REQ-008 carryborrow_in  input  1  carry-in (add) or borrow-in (subtract); full mode only.
REQ-009 in_valid  input  1  operands and modes qualified this cycle.
REQ-010 carryborrow_out  output  1  registered carry-out (add) or borrow-out (subtract).
REQ-011 sumdiff  output  1  registered sum (add) or difference (subtract).
REQ-012 out_valid  output  1  high for one cycle when carryborrow_out/sumdiff hold a new result.

Function
REQ-013 Effective incoming bit c = carryborrow_in when mode_halffull = 1, else c = 0.
REQ-014 Add (mode_addsub = 0): sumdiff = A xor B xor c; carryborrow_out = (A and B) or (c and (A xor B)).
REQ-015 Subtract (mode_addsub = 1): sumdiff = A xor B xor c; carryborrow_out = (not A and B) or (c and not (A xor B)).
REQ-016 Arithmetic identity: add gives {carryborrow_out, sumdiff} = A + B + c; subtract gives sumdiff = (A - B - c) mod 2, carryborrow_out = 1 when A < B + c.
REQ-017 All inputs (modes, operands, carryborrow_in) are sampled together on the same rising edge when in_valid = 1; modes may change every cycle.
REQ-018 Latency: result of inputs sampled at edge N appears on outputs after edge N, with out_valid = 1 for exactly that cycle.
REQ-019 When in_valid = 0 at an edge: out_valid goes 0 after that edge; carryborrow_out and sumdiff hold their previous values.
REQ-020 Back-to-back in_valid = 1 yields one result per cycle with no bubbles; no backpressure input exists.
REQ-021 In half mode carryborrow_in has no effect on any output, including X/unknown values on it.
REQ-022 Outputs are driven only from flip-flops; no combinational path from any input to any output.

Reset
REQ-023 When rst_n = 0 at a rising edge: carryborrow_out = 0, sumdiff = 0, out_valid = 0 after that edge, regardless of in_valid.
REQ-024 Reset overrides a simultaneous in_valid = 1; that input is discarded, not delayed.
REQ-025 First result after reset release is from the first edge with rst_n = 1 and in_valid = 1.

Verification
REQ-026 Reset: hold rst_n = 0 two cycles with in_valid = 1, A = B = 1 -> carryborrow_out = 0, sumdiff = 0, out_valid = 0.
REQ-027 Full add sweep (add, full): all 8 {A,B,cin} combinations 000..111, one per cycle -> {cbo,sd} = 00,01,01,10,01,10,10,11, each one cycle later, out_valid held 1.
REQ-028 Full subtract sweep (sub, full): same 8 combinations -> {cbo,sd} = 00,11,11,10,01,00,00,11.
REQ-029 Half modes: add-half and sub-half, all 8 combinations -> cin ignored; add {A,B}=00,01,10,11 -> 00,01,01,10; sub -> 00,11,01,00.
REQ-030 Mode switch and gaps: alternate mode_addsub each cycle with A=0,B=1,cin=0 full, insert one in_valid = 0 cycle -> 01,11, then out_valid = 0 with outputs held at 11, then resumes.
REQ-031 Mid-stream reset: assert rst_n = 0 for one cycle during sweep -> outputs 0 next cycle, sweep results resume only for inputs applied after release.
